mult_adder_seq: RTL and testbench
=================================

// Module: mult_adder_seq
// PURPOSE
//   Responder side of the fully-connected layers' MultAdder interface: accepts two
//   NUM_ELEMS-element signed int8 operand vectors and returns their saturated dot product.
//   Sits between full_connect* (initiator) and nothing else; time-multiplexes LANES
//   multipliers over NUM_ELEMS/LANES beats instead of a 128-wide combinational array.
// PARAMETERS
//   NUM_ELEMS  128  elements per operand vector
//   ELEM_W     8    element width, signed two's complement
//   LANES      16   multiply lanes per beat; NUM_ELEMS % LANES == 0
//   RESULT_W   15   result width, signed
//   ACC_W      24   internal accumulator width; >= 2*ELEM_W + clog2(NUM_ELEMS)
// PORTS
//   clk       in   1                    clock, rising edge
//   iRst      in   1                    asynchronous reset, active-high
//   ena       in   1                    global enable; low freezes all state
//   start     in   1                    request; sampled only in IDLE with ena=1
//   opr1      in   NUM_ELEMS*ELEM_W     operand vector A, element i at [i*8 +: 8]
//   opr2      in   NUM_ELEMS*ELEM_W     operand vector B, same packing
//   busy      out  1                    high from accepted start until done cycle inclusive
//   done      out  1                    one-cycle pulse; result/overflow valid this cycle
//   result    out  RESULT_W             saturated dot product, held until next done
//   overflow  out  1                    1 if true sum outside RESULT_W signed range; held
// BEHAVIOUR
//   Reset (iRst=1, async): state=IDLE, busy=0, done=0, result=0, overflow=0, acc=0, beat=0.
//   States: IDLE -> ACCUM -> FINISH -> IDLE.
//   IDLE: on start&&ena latch opr1/opr2 into operand regs, acc<=0, beat<=0, busy<=1, ->ACCUM.
//     Initiator may change opr1/opr2 after the accepting edge.
//   ACCUM: each enabled cycle acc += sum of LANES products of elements
//     [beat*LANES +: LANES]; beat++; after beat BEATS-1 (BEATS=NUM_ELEMS/LANES=8) ->FINISH.
//   FINISH: if acc > 2^(RESULT_W-1)-1 (16383): result=16383, overflow=1;
//     if acc < -2^(RESULT_W-1) (-16384): result=-16384, overflow=1;
//     else result=acc[RESULT_W-1:0], overflow=0. done=1 for this cycle, busy=0 next, ->IDLE.
//   Latency: start edge to done-high = BEATS+1 enabled cycles (9 at defaults).
//   Products: signed ELEM_W x ELEM_W -> 2*ELEM_W, sign-extended to ACC_W; acc never wraps.
//   start while busy: ignored, no queueing. start in FINISH cycle: ignored; earliest
//     accepted start is the cycle after done.
//   ena=0: state, beat, acc, done, result held; done pulse stretched while ena low.
//   Reset mid-operation: abort immediately, no done, outputs to reset values.
//   Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   Shared package (tpu_pkg): ELEM_W, NUM_ELEMS, RESULT_W constants, state enum
//     {IDLE, ACCUM, FINISH}, RESULT_MAX/RESULT_MIN saturation constants.
//   Sub-module mac_lane_sum: combinational LANES-wide signed multiply + adder tree,
//     in LANES*ELEM_W x2, out 2*ELEM_W+clog2(LANES) signed. Top holds FSM, regs, saturation.
// TESTING
//   1. opr1 all 8'h01, opr2 all 8'h02, start 1 cycle -> done after 9 cycles, result=256, ovf=0.
//   2. all 8'h7F x all 8'h7F (sum 2064512) -> result=16383 (15'h3FFF), overflow=1.
//   3. all 8'h80 x all 8'h7F (sum -2080768) -> result=-16384 (15'h4000), overflow=1.
//   4. opr1 alternating +5/-5, opr2 all 3 -> result=0; element 127 only =-1 x 100 -> -100.
//   5. second start pulses during busy -> ignored, exactly one done; start cycle after done
//      -> accepted, second done 9 cycles later; change opr after accept -> result unchanged.
//   6. ena low 3 cycles mid-ACCUM -> done delayed 3 cycles, same result; iRst mid-ACCUM ->
//      busy/done/result/overflow 0 at once, no done until new start.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants, FSM state type and result saturation helper for the
// fully-connected MultAdder datapath.
package tpu_pkg;

  localparam int NUM_ELEMS  = 128;
  localparam int ELEM_W     = 8;
  localparam int LANES      = 16;
  localparam int RESULT_W   = 15;
  localparam int ACC_W      = 24;
  localparam int BEATS      = NUM_ELEMS / LANES;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int VEC_W      = NUM_ELEMS * ELEM_W;
  localparam int BEAT_BITS  = LANES * ELEM_W;
  localparam int LANE_SUM_W = 2 * ELEM_W + $clog2(LANES);

  localparam int RESULT_MAX = (2 ** (RESULT_W - 1)) - 1;
  localparam int RESULT_MIN = -(2 ** (RESULT_W - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef struct packed {
    logic                       overflow;
    logic signed [RESULT_W-1:0] value;
  } sat_t;

  function automatic sat_t saturate(input logic signed [ACC_W-1:0] acc);
    sat_t r;
    if (acc > ACC_W'(RESULT_MAX)) begin
      r.overflow = 1'b1;
      r.value    = RESULT_W'(RESULT_MAX);
    end else if (acc < ACC_W'(RESULT_MIN)) begin
      r.overflow = 1'b1;
      r.value    = RESULT_W'(RESULT_MIN);
    end else begin
      r.overflow = 1'b0;
      r.value    = acc[RESULT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// One beat of the dot product: LANES signed int8 multiplies summed into a
// single signed value wide enough that it can never overflow.
module mac_lane_sum
  import tpu_pkg::*;
(
  input  logic        [BEAT_BITS-1:0]  a_i,
  input  logic        [BEAT_BITS-1:0]  b_i,
  output logic signed [LANE_SUM_W-1:0] sum_o
);

  logic signed [2*ELEM_W-1:0] prod_s [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign prod_s[g] = $signed(a_i[g*ELEM_W +: ELEM_W]) * $signed(b_i[g*ELEM_W +: ELEM_W]);
  end

  logic signed [LANE_SUM_W-1:0] sum_s;

  // Sign-extend every product before summing so the sum stays exact.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + LANE_SUM_W'(prod_s[i]);
    end
  end

  assign sum_o = sum_s;

endmodule

// File: rtl/mult_adder_seq.sv
// Sequential dot-product responder: LANES multipliers reused over BEATS cycles,
// followed by one saturation cycle that raises the done pulse.
module mult_adder_seq
  import tpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       iRst,
  input  logic                       ena,
  input  logic                       start,
  input  logic        [VEC_W-1:0]    opr1,
  input  logic        [VEC_W-1:0]    opr2,
  output logic                       busy,
  output logic                       done,
  output logic signed [RESULT_W-1:0] result,
  output logic                       overflow
);

  state_e                       state_q, state_d;
  logic        [VEC_W-1:0]      opa_q, opa_d;
  logic        [VEC_W-1:0]      opb_q, opb_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic        [BEAT_W-1:0]     beat_q, beat_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic signed [RESULT_W-1:0]   result_q, result_d;
  logic                         ovf_q, ovf_d;
  logic signed [LANE_SUM_W-1:0] lane_sum_s;
  sat_t                         sat_s;

  // Operands shift down one beat per cycle, so the lanes always see the low slice.
  mac_lane_sum u_lane_sum (
    .a_i   (opa_q[BEAT_BITS-1:0]),
    .b_i   (opb_q[BEAT_BITS-1:0]),
    .sum_o (lane_sum_s)
  );

  assign sat_s = saturate(acc_q);

  // State register.
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; busy_q still high marks the done cycle, where start is ignored.
  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
        ACCUM: begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = FINISH;
          end else begin
            state_d = ACCUM;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output next values; everything holds while ena is low.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (start && !busy_q) begin
            opa_d  = opr1;
            opb_d  = opr2;
            acc_d  = '0;
            beat_d = '0;
            busy_d = 1'b1;
          end else begin
            busy_d = 1'b0;
          end
        end
        ACCUM: begin
          acc_d  = acc_q + ACC_W'(lane_sum_s);
          beat_d = beat_q + BEAT_W'(1);
          opa_d  = opa_q >> BEAT_BITS;
          opb_d  = opb_q >> BEAT_BITS;
        end
        FINISH: begin
          result_d = sat_s.value;
          ovf_d    = sat_s.overflow;
          done_d   = 1'b1;
        end
        default: begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end
      endcase
    end else begin
      done_d = done_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mult_adder_seq.sv
// Scoreboard bench for mult_adder_seq: expected results are queued on issue
// and compared when the done pulse rises.
module tb_mult_adder_seq;
  import tpu_pkg::*;

  logic                       clk = 1'b0;
  logic                       iRst;
  logic                       ena;
  logic                       start;
  logic        [VEC_W-1:0]    opr1;
  logic        [VEC_W-1:0]    opr2;
  logic                       busy;
  logic                       done;
  logic signed [RESULT_W-1:0] result;
  logic                       overflow;

  int          vec_cnt    = 0;
  int          mis_cnt    = 0;
  int          cyc        = 0;
  int          accept_cyc = 0;
  int          done_cnt   = 0;
  int          done_cyc   = 0;
  logic        done_prev  = 1'b0;
  logic [15:0] sb_e;
  logic [15:0] exp_q [$];

  mult_adder_seq dut (
    .clk      (clk),
    .iRst     (iRst),
    .ena      (ena),
    .start    (start),
    .opr1     (opr1),
    .opr2     (opr2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VEC_W-1:0] fill(input logic [7:0] v);
    return {NUM_ELEMS{v}};
  endfunction

  // Reference: exact integer dot product, then clamp to the 15-bit range.
  function automatic logic [15:0] model(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    int s;
    logic [7:0] ea;
    logic [7:0] eb;
    s = 0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      ea = a[i*8 +: 8];
      eb = b[i*8 +: 8];
      s += int'($signed(ea)) * int'($signed(eb));
    end
    if (s > 16383)       return {1'b1, 15'h3FFF};
    else if (s < -16384) return {1'b1, 15'h4000};
    else                 return {1'b0, s[14:0]};
  endfunction

  // Monitor: each rising done pops one expectation.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (iRst !== 1'b1 && done === 1'b1 && done_prev === 1'b0) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check_val("result", {17'b0, result}, {17'b0, sb_e[14:0]});
          check_val("overflow", {31'b0, overflow}, {31'b0, sb_e[15]});
        end
      end
      done_prev = (done === 1'b1) && (iRst !== 1'b1);
    end
  end

  task automatic scramble();
    for (int i = 0; i < VEC_W / 32; i++) begin
      opr1[i*32 +: 32] = $urandom();
      opr2[i*32 +: 32] = $urandom();
    end
  endtask

  task automatic issue(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input bit push);
    @(negedge clk);
    opr1  = a;
    opr2  = b;
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    start      = 1'b0;
    accept_cyc = cyc;
    scramble();
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int  c0;
    bit  got;
    c0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != c0) got = 1'b1;
    end
    check_val({tag, "_seen"}, {31'b0, got}, 32'd1);
    if (got) check_val({tag, "_lat"}, done_cyc - accept_cyc, exp_lat);
  endtask

  logic [VEC_W-1:0] va;
  logic [VEC_W-1:0] vb;
  int               c_snap;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    iRst  = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
    opr1  = '0;
    opr2  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_result", {17'b0, result}, 32'd0);
    check_val("rst_ovf", {31'b0, overflow}, 32'd0);
    iRst = 1'b0;

    issue(fill(8'h01), fill(8'h02), 1'b1);
    #1;
    check_val("busy_run", {31'b0, busy}, 32'd1);
    wait_done("t1", 9);
    check_val("busy_done_cycle", {31'b0, busy}, 32'd1);

    issue(fill(8'h7F), fill(8'h7F), 1'b1);
    wait_done("t2_pos_sat", 9);
    issue(fill(8'h80), fill(8'h7F), 1'b1);
    wait_done("t3_neg_sat", 9);

    for (int i = 0; i < NUM_ELEMS; i++) va[i*8 +: 8] = (i % 2 == 0) ? 8'sd5 : -8'sd5;
    issue(va, fill(8'h03), 1'b1);
    wait_done("t4_alt", 9);
    va = '0;
    va[127*8 +: 8] = 8'hFF;
    issue(va, fill(8'd100), 1'b1);
    wait_done("t4_last", 9);

    // Starts during busy are dropped; a start the cycle after done is taken.
    for (int i = 0; i < NUM_ELEMS; i++) begin
      va[i*8 +: 8] = 8'($urandom_range(0, 255));
      vb[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
    issue(va, vb, 1'b1);
    @(negedge clk); start = 1'b1; opr1 = fill(8'h7F); opr2 = fill(8'h7F);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("t5_busy_ign", 9);
    issue(fill(8'h04), fill(8'hFD), 1'b1);
    wait_done("t5_after_done", 9);
    c_snap = done_cnt;
    start  = 1'b1;
    opr1   = fill(8'h11);
    opr2   = fill(8'h11);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("t5_done_cycle_start", {31'b0, busy}, 32'd0);
    repeat (14) @(negedge clk);
    check_val("t5_single_done", done_cnt - c_snap, 32'd0);

    // ena low for three edges stretches latency by three.
    issue(fill(8'h02), fill(8'h09), 1'b1);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    wait_done("t6_ena", 12);

    issue(fill(8'h05), fill(8'h05), 1'b0);
    repeat (4) @(negedge clk);
    iRst = 1'b1;
    #1;
    check_val("t6_rst_busy", {31'b0, busy}, 32'd0);
    check_val("t6_rst_done", {31'b0, done}, 32'd0);
    check_val("t6_rst_result", {17'b0, result}, 32'd0);
    check_val("t6_rst_ovf", {31'b0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    iRst   = 1'b0;
    c_snap = done_cnt;
    repeat (15) @(negedge clk);
    check_val("t6_no_done_after_rst", done_cnt - c_snap, 32'd0);

    issue(fill(8'h03), fill(8'hFE), 1'b1);
    wait_done("t6_restart", 9);

    check_val("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
